// File: rtl/exp_golomb_dec_seq.sv
// Exp-Golomb decoder sequencer: unpacks parallel words into the serial
// decoder input, tracks codeword boundaries and registers decoded symbols.
module exp_golomb_dec_seq #(
   parameter int WORD_W     = 32,
   parameter int DATA_WIDTH = 8,
   parameter int LZ_W       = 4,
   parameter int MAX_LZ     = 7,
   parameter int TMO        = 3
) (
   input  logic                  clk_i,
   input  logic                  rstn_b_w,
   input  logic [WORD_W-1:0]     word_i,
   input  logic                  word_valid_i,
   output logic                  word_ready_o,
   output logic                  dec_dt_o,
   output logic                  dec_valid_o,
   input  logic [DATA_WIDTH-1:0] dec_dt_i,
   input  logic                  dec_valid_i,
   output logic [DATA_WIDTH-1:0] sym_o,
   output logic                  sym_valid_o,
   input  logic                  sym_ready_i,
   output logic                  busy_o,
   output logic                  err_o,
   output logic [15:0]           sym_cnt_o
);

   localparam int CNT_W = $clog2(WORD_W + 1);
   localparam int TMR_W = (TMO > 1) ? $clog2(TMO + 1) : 1;

   typedef enum logic [2:0] {
      IDLE, ZEROS, SUFFIX, WAIT, GAP, ERR
   } state_t;

   state_t            state;
   logic [WORD_W-1:0] bits;
   logic [CNT_W-1:0]  left;
   logic [LZ_W-1:0]   lz;
   logic [LZ_W-1:0]   rem;
   logic [TMR_W-1:0]  tmr;
   logic              have_bit;
   logic              cur_bit;
   logic              overlong;
   logic              issue;
   logic              load;

   assign have_bit     = (left != '0);
   assign cur_bit      = bits[WORD_W-1];
   assign overlong     = !cur_bit && (lz == LZ_W'(MAX_LZ));
   assign word_ready_o = !have_bit && (state != ERR);
   assign load         = word_valid_i && word_ready_o;
   assign dec_valid_o  = issue;
   assign dec_dt_o     = cur_bit;
   assign busy_o       = (state != IDLE);

   // Decide whether the current buffer bit goes to the decoder this cycle
   always_comb begin
      issue = 1'b0;
      case (state)
         IDLE:    issue = have_bit && !sym_valid_o;
         ZEROS:   issue = have_bit && !overlong;
         SUFFIX:  issue = have_bit;
         default: issue = 1'b0;
      endcase
   end

   // Bit buffer: load a full word when empty, shift out MSB first
   always_ff @(posedge clk_i or negedge rstn_b_w) begin
      if (!rstn_b_w) begin
         bits <= '0;
         left <= '0;
      end else if (load) begin
         bits <= word_i;
         left <= CNT_W'(WORD_W);
      end else if (issue) begin
         bits <= {bits[WORD_W-2:0], 1'b0};
         left <= left - CNT_W'(1);
      end
   end

   // Codeword tracking FSM with registered symbol, error and count outputs
   always_ff @(posedge clk_i or negedge rstn_b_w) begin
      if (!rstn_b_w) begin
         state       <= IDLE;
         lz          <= '0;
         rem         <= '0;
         tmr         <= '0;
         sym_o       <= '0;
         sym_valid_o <= 1'b0;
         err_o       <= 1'b0;
         sym_cnt_o   <= '0;
      end else begin
         if (sym_valid_o && sym_ready_i) begin
            sym_valid_o <= 1'b0;
            sym_cnt_o   <= sym_cnt_o + 16'd1;
         end
         case (state)
            IDLE: begin
               if (issue) begin
                  if (cur_bit) begin
                     state <= WAIT;
                     tmr   <= '0;
                     lz    <= '0;
                  end else begin
                     state <= ZEROS;
                     lz    <= LZ_W'(1);
                  end
               end
            end
            ZEROS: begin
               if (have_bit) begin
                  if (overlong) begin
                     state <= ERR;
                     err_o <= 1'b1;
                  end else if (!cur_bit) begin
                     lz <= lz + LZ_W'(1);
                  end else begin
                     state <= SUFFIX;
                     rem   <= lz;
                  end
               end
            end
            SUFFIX: begin
               if (issue) begin
                  rem <= rem - LZ_W'(1);
                  if (rem == LZ_W'(1)) begin
                     state <= WAIT;
                     tmr   <= '0;
                  end
               end
            end
            WAIT: begin
               if (dec_valid_i) begin
                  sym_o       <= dec_dt_i;
                  sym_valid_o <= 1'b1;
                  state       <= GAP;
               end else if (tmr == TMR_W'(TMO - 1)) begin
                  state <= ERR;
                  err_o <= 1'b1;
               end else begin
                  tmr <= tmr + TMR_W'(1);
               end
            end
            GAP:     state <= IDLE;
            ERR:     state <= ERR;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_exp_golomb_dec_seq.sv
// Bench for exp_golomb_dec_seq: behavioural decoder model on the serial
// side, reference decode of the word stream, directed and random steps.
module tb_exp_golomb_dec_seq;

   localparam int MAX_LZ = 7;

   logic        clk_i        = 1'b0;
   logic        rstn_b_w     = 1'b0;
   logic [31:0] word_i       = '0;
   logic        word_valid_i = 1'b0;
   logic        word_ready_o;
   logic        dec_dt_o;
   logic        dec_valid_o;
   logic [7:0]  dec_dt_i     = '0;
   logic        dec_valid_i  = 1'b0;
   logic [7:0]  sym_o;
   logic        sym_valid_o;
   logic        sym_ready_i  = 1'b0;
   logic        busy_o;
   logic        err_o;
   logic [15:0] sym_cnt_o;

   always #5 clk_i = ~clk_i;

   exp_golomb_dec_seq dut (
      .clk_i        (clk_i),
      .rstn_b_w     (rstn_b_w),
      .word_i       (word_i),
      .word_valid_i (word_valid_i),
      .word_ready_o (word_ready_o),
      .dec_dt_o     (dec_dt_o),
      .dec_valid_o  (dec_valid_o),
      .dec_dt_i     (dec_dt_i),
      .dec_valid_i  (dec_valid_i),
      .sym_o        (sym_o),
      .sym_valid_o  (sym_valid_o),
      .sym_ready_i  (sym_ready_i),
      .busy_o       (busy_o),
      .err_o        (err_o),
      .sym_cnt_o    (sym_cnt_o)
   );

   int          passed = 0;
   int          fails  = 0;
   int          total  = 0;
   logic [31:0] wq[$];
   logic [31:0] words_in[$];
   int          exp_q[$];
   int          got[$];
   logic        took, ready_en, rand_ready, withhold, bubble;
   logic        s1_v, s2_v;
   logic [7:0]  s1_d, s2_d;
   int          m_phase, m_lz, m_rem, m_suf, issued;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] expv);
      total++;
      assert (obs === expv) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic emit(input int v);
      s1_v = 1'b1;
      s1_d = 8'(v);
   endtask

   // Behavioural serial decoder: value = (1 << lz) - 1 + suffix
   task automatic model_bit(input logic b);
      if (m_phase == 0) begin
         if (!b) m_lz++;
         else if (m_lz == 0) emit(0);
         else begin
            m_phase = 1;
            m_rem   = m_lz;
            m_suf   = 0;
         end
      end else begin
         m_suf = m_suf * 2 + int'(b);
         m_rem--;
         if (m_rem == 0) begin
            emit((1 << m_lz) - 1 + m_suf);
            m_phase = 0;
            m_lz    = 0;
         end
      end
   endtask

   task automatic tick();
      @(negedge clk_i);
      if (took) begin
         word_valid_i = 1'b0;
         took         = 1'b0;
      end
      if (!word_valid_i && wq.size() > 0) begin
         word_i       = wq.pop_front();
         word_valid_i = 1'b1;
      end
      if (word_valid_i && word_ready_o) took = 1'b1;
      sym_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : ready_en;
      if (sym_valid_o && sym_ready_i) got.push_back(int'(sym_o));
      dec_valid_i = s2_v && !withhold;
      dec_dt_i    = s2_d;
      s2_v = s1_v;
      s2_d = s1_d;
      s1_v = 1'b0;
      if (dec_valid_o) begin
         issued++;
         model_bit(dec_dt_o);
      end
      if (busy_o && !dec_valid_o && word_ready_o && !err_o) bubble = 1'b1;
   endtask

   task automatic do_reset();
      rstn_b_w     = 1'b0;
      word_valid_i = 1'b0;
      dec_valid_i  = 1'b0;
      took = 1'b0; s1_v = 1'b0; s2_v = 1'b0; s1_d = '0; s2_d = '0;
      wq.delete(); words_in.delete(); got.delete();
      m_phase = 0; m_lz = 0; m_rem = 0; m_suf = 0;
      issued = 0; bubble = 1'b0;
      repeat (2) @(negedge clk_i);
      rstn_b_w = 1'b1;
   endtask

   task automatic push(input logic [31:0] w);
      wq.push_back(w);
      words_in.push_back(w);
   endtask

   // Reference: decode the whole pushed bit stream with plain arithmetic
   task automatic ref_decode();
      bit bs[$];
      int p, n, lz, v;
      exp_q.delete();
      foreach (words_in[i])
         for (int k = 31; k >= 0; k--) bs.push_back(words_in[i][k]);
      n = bs.size();
      p = 0;
      while (1) begin
         lz = 0;
         while (p < n && !bs[p]) begin
            lz++;
            p++;
         end
         if (p >= n || lz > MAX_LZ) break;
         p++;
         if (p + lz > n) break;
         v = 1;
         for (int j = 0; j < lz; j++) begin
            v = v * 2 + int'(bs[p]);
            p++;
         end
         exp_q.push_back(v - 1);
      end
   endtask

   task automatic run_cmp(input string tag, input int budget);
      int bad;
      ref_decode();
      for (int i = 0; i < budget && got.size() < exp_q.size(); i++) tick();
      chk({tag, "_count"}, got.size(), exp_q.size());
      bad = 0;
      foreach (exp_q[i])
         if (i >= got.size() || got[i] != exp_q[i]) bad++;
      chk({tag, "_syms"}, bad, 0);
   endtask

   function automatic logic [29:0] outs();
      return {word_ready_o, dec_valid_o, dec_dt_o, sym_valid_o, sym_o,
              err_o, busy_o, sym_cnt_o};
   endfunction

   initial begin
      logic [29:0] rst_vec;
      logic [7:0]  held;
      bit          rb[$];
      int          bad, v, x, lz;
      logic [31:0] w;

      rst_vec = {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000};
      ready_en = 1'b1; rand_ready = 1'b0; withhold = 1'b0;

      // reset values and latency on the first '1' codeword
      do_reset();
      chk("reset_outs", outs(), rst_vec);
      push(32'hA64F_FFFF);
      for (int i = 0; i < 10 && !dec_valid_o; i++) tick();
      chk("lat_t0", {dec_valid_o, dec_dt_o}, 2'b11);
      tick(); chk("lat_t1", dec_valid_o, 1'b0);
      tick(); chk("lat_t2", {dec_valid_o, sym_valid_o}, 2'b00);
      tick(); chk("lat_t3", {dec_valid_o, sym_valid_o}, 2'b01);
      chk("lat_t3_sym", sym_o, 8'd0);
      tick(); chk("lat_t4", dec_valid_o, 1'b1);
      run_cmp("word1", 400);
      tick();
      chk("word1_cnt", sym_cnt_o, 16'd24);
      chk("word1_err", err_o, 1'b0);

      // codeword spanning a word boundary
      do_reset();
      push(32'hFFFF_FFFC);
      push(32'h9FFF_FFFF);
      run_cmp("span", 600);
      chk("span_bubble", bubble, 1'b1);
      tick();
      chk("span_cnt", sym_cnt_o, 16'd60);

      // backpressure holds the symbol and blocks the next codeword
      do_reset();
      ready_en = 1'b0;
      push(32'hA64F_FFFF);
      for (int i = 0; i < 20 && !sym_valid_o; i++) tick();
      chk("bp_first", sym_valid_o, 1'b1);
      held = sym_o;
      bad  = 0;
      repeat (10) begin
         tick();
         if (!(sym_valid_o && sym_o == held && !dec_valid_o)) bad++;
      end
      chk("bp_hold", bad, 0);
      ready_en = 1'b1;
      run_cmp("bp", 400);

      // all-zero word: overlong prefix
      do_reset();
      push(32'h0000_0000);
      repeat (30) tick();
      chk("zero_issued", issued, 7);
      chk("zero_err", err_o, 1'b1);
      chk("zero_dvalid", dec_valid_o, 1'b0);
      chk("zero_wready", word_ready_o, 1'b0);
      repeat (5) tick();
      chk("zero_sticky", {err_o, word_ready_o, busy_o}, 3'b101);
      chk("zero_nosym", got.size(), 0);

      // decoder never answers: timeout error
      do_reset();
      withhold = 1'b1;
      push(32'hA64F_FFFF);
      for (int i = 0; i < 10 && !dec_valid_o; i++) tick();
      repeat (3) tick();
      chk("tmo_before", err_o, 1'b0);
      tick();
      chk("tmo_err", err_o, 1'b1);
      withhold = 1'b0;

      // asynchronous reset in the middle of a suffix
      do_reset();
      push(32'h2FFF_FFFF);
      for (int i = 0; i < 20 && issued < 4; i++) tick();
      chk("mid_busy", {busy_o, sym_valid_o}, 2'b10);
      #2 rstn_b_w = 1'b0;
      #1 chk("mid_reset", outs(), rst_vec);

      // random codeword stream with random downstream readiness
      do_reset();
      rand_ready = 1'b1;
      rb.delete();
      while (1) begin
         v  = $urandom_range(0, 254);
         x  = v + 1;
         lz = 0;
         while ((x >> (lz + 1)) != 0) lz++;
         if (rb.size() + 2 * lz + 1 > 128) break;
         repeat (lz) rb.push_back(1'b0);
         for (int k = lz; k >= 0; k--) rb.push_back(bit'((x >> k) & 1));
      end
      while (rb.size() < 128) rb.push_back(1'b1);
      for (int i = 0; i < 4; i++) begin
         for (int k = 0; k < 32; k++) w[31-k] = rb[i*32+k];
         push(w);
      end
      run_cmp("rand", 3000);
      rand_ready = 1'b0;
      ready_en   = 1'b1;
      tick();
      chk("rand_cnt", sym_cnt_o, 16'(got.size()));
      chk("rand_err", err_o, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
